ofm_writeback: RTL and testbench
================================

OFM_WRITEBACK -- requirements
Module: ofm_writeback

Interface
REQ-001 SHALL have parameter OFM_BASE, default 0: word address of the first output word.
REQ-002 SHALL have parameter TOTAL_PIX, default 2916: number of 16-channel output vectors per layer, equal to 54x54.
REQ-003 SHALL have parameter CH_GROUPS, default 2: number of 16-channel groups per pixel, equal to 32/16.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is sampled on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: a one-cycle pulse that arms the block for one layer.
REQ-007 SHALL have port valid, input, 16 bits: per-PE output-valid flags from the PE cluster.
REQ-008 SHALL have ports OFM_0..OFM_15, input, 8 bits each: PE results; lane i is OFM_i.
REQ-009 SHALL have port wr_en, output, 1 bit: OFM BRAM write strobe.
REQ-010 SHALL have port wr_addr, output, 32 bits: OFM BRAM word address.
REQ-011 SHALL have port wr_data, output, 32 bits: OFM BRAM write data.
REQ-012 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-013 SHALL have port done, output, 1 bit: high while in DONE.
REQ-014 SHALL have port overflow, output, 1 bit: sticky flag; a vector was dropped because the buffer was full.
REQ-015 SHALL have port lane_err, output, 1 bit: sticky flag; valid was partial (nonzero but not 16'hFFFF).

Function
REQ-016 SHALL implement an FSM with states IDLE, RUN and DONE; reset enters IDLE.
REQ-017 SHALL move IDLE->RUN or DONE->RUN on start, clearing all counters, the buffer, overflow and lane_err.
REQ-018 SHALL treat start in RUN as a restart: the buffer is flushed, counters are cleared, wr_en is 0 next cycle and the state stays RUN.
REQ-019 SHALL capture one vector {OFM_15..OFM_0} only in RUN, on a cycle with valid==16'hFFFF; valid is ignored in IDLE and DONE.
REQ-020 SHALL not capture when valid is partial (nonzero and not 16'hFFFF), and SHALL set lane_err.
REQ-021 SHALL hold captures in a 2-entry FIFO, 128 bits per entry.
REQ-022 SHALL, when a capture arrives while the FIFO is full, drop it, set overflow, and leave the capture count unchanged.
REQ-023 SHALL accept a capture without overflow when the FIFO is full and its head entry issues its last word in the same cycle.
REQ-024 SHALL drain the head entry as 4 consecutive writes, word k=0..3, with wr_data={OFM_4k+3,OFM_4k+2,OFM_4k+1,OFM_4k}, where OFM_4k occupies [7:0].
REQ-025 SHALL give each write the address wr_addr=OFM_BASE+4*n+k, where n is the 0-based drained-vector index; the address wraps modulo 2^32.
REQ-026 SHALL have latency as follows: a capture at edge t into an empty FIFO produces wr_en=1 on cycles t+1..t+4; the first word is registered.
REQ-027 SHALL sustain back-to-back drains with no idle cycle between entries, giving 1 vector per 4 cycles.
REQ-028 SHALL count captures up to TOTAL_PIX*CH_GROUPS; further valid vectors in RUN are ignored and do not set overflow.
REQ-029 SHALL move RUN->DONE on the cycle after the last word of vector TOTAL_PIX*CH_GROUPS-1 is written.
REQ-030 SHALL keep wr_en=0 whenever wr_addr and wr_data are don't-care.

Reset
REQ-031 SHALL, on reset, set the state to IDLE and clear wr_en, wr_addr, wr_data, busy, done, overflow, lane_err, the FIFO and all counters to 0, overriding start and valid in the same cycle.
REQ-032 SHALL, on reset asserted mid-drain, abort the drain with wr_en=0 from the next cycle and write no partial vector afterward.

Verification
REQ-033 SHALL be verified by: start, then one capture with OFM_i=i+1 -> writes at cycles t+1..t+4, addr 0..3, data 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D.
REQ-034 SHALL be verified by: captures on 3 consecutive cycles -> the third is dropped, overflow=1, exactly 8 writes at addr 0..7.
REQ-035 SHALL be verified by: TOTAL_PIX=2, CH_GROUPS=2, with 5 captures spaced 6 cycles apart -> 16 writes, done=1 and busy=0 after the 16th, and the 5th capture is ignored.
REQ-036 SHALL be verified by: valid=16'h00FF in RUN -> no write and lane_err=1; a following start -> lane_err=0.
REQ-037 SHALL be verified by: reset asserted at the 2nd write of a drain -> wr_en=0 afterward, all outputs 0, state IDLE, and valid ignored until start.
REQ-038 SHALL be verified by: OFM_BASE=0xFFFFFFFE with one capture -> wr_addr sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.

Source files
------------

// File: rtl/ofm_writeback.sv
// Output feature-map writeback: captures 16-lane PE result vectors into a 2-entry
// buffer and drains each one as four 32-bit BRAM writes at consecutive word addresses.
module ofm_writeback #(
   parameter logic [31:0] OFM_BASE  = 32'h0000_0000,
   parameter int unsigned TOTAL_PIX = 2916,
   parameter int unsigned CH_GROUPS = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] valid,
   input  logic [7:0]  OFM_0,
   input  logic [7:0]  OFM_1,
   input  logic [7:0]  OFM_2,
   input  logic [7:0]  OFM_3,
   input  logic [7:0]  OFM_4,
   input  logic [7:0]  OFM_5,
   input  logic [7:0]  OFM_6,
   input  logic [7:0]  OFM_7,
   input  logic [7:0]  OFM_8,
   input  logic [7:0]  OFM_9,
   input  logic [7:0]  OFM_10,
   input  logic [7:0]  OFM_11,
   input  logic [7:0]  OFM_12,
   input  logic [7:0]  OFM_13,
   input  logic [7:0]  OFM_14,
   input  logic [7:0]  OFM_15,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic        lane_err
);

   localparam int unsigned NumVec  = TOTAL_PIX * CH_GROUPS;
   localparam logic [31:0] LastVec = 32'(NumVec);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e        state_q, state_d;
   logic [127:0]  mem_q [2];
   logic          wr_ptr_q, wr_ptr_d;
   logic          rd_ptr_q, rd_ptr_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [1:0]    word_q, word_d;
   logic [31:0]   cap_cnt_q, cap_cnt_d;
   logic [31:0]   vec_cnt_q, vec_cnt_d;
   logic [31:0]   addr_q, addr_d;
   logic          wr_en_q, wr_en_d;
   logic [31:0]   wr_addr_q, wr_addr_d;
   logic [31:0]   wr_data_q, wr_data_d;
   logic          overflow_q, overflow_d;
   logic          lane_err_q, lane_err_d;
   logic          push, pop;
   logic [127:0]  cap_vec;
   logic [127:0]  head;

   assign cap_vec = {OFM_15, OFM_14, OFM_13, OFM_12, OFM_11, OFM_10, OFM_9, OFM_8,
                     OFM_7, OFM_6, OFM_5, OFM_4, OFM_3, OFM_2, OFM_1, OFM_0};
   assign head    = mem_q[rd_ptr_q];

   // Next-state: FSM, buffer push/pop, drain sequencing and sticky flags.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      word_d     = word_q;
      cap_cnt_d  = cap_cnt_q;
      vec_cnt_d  = vec_cnt_q;
      addr_d     = addr_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      overflow_d = overflow_q;
      lane_err_d = lane_err_q;
      push       = 1'b0;
      pop        = 1'b0;

      if (start) begin
         // Arm or restart: flush the buffer and rewind every counter.
         state_d    = StRun;
         wr_ptr_d   = 1'b0;
         rd_ptr_d   = 1'b0;
         cnt_d      = 2'd0;
         word_d     = 2'd0;
         cap_cnt_d  = 32'd0;
         vec_cnt_d  = 32'd0;
         addr_d     = OFM_BASE;
         overflow_d = 1'b0;
         lane_err_d = 1'b0;
      end else if (state_q == StRun) begin
         if (cnt_q != 2'd0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = head[{word_q, 5'b00000} +: 32];
            addr_d    = addr_q + 32'd1;
            if (word_q == 2'd3) begin
               pop       = 1'b1;
               word_d    = 2'd0;
               rd_ptr_d  = ~rd_ptr_q;
               vec_cnt_d = vec_cnt_q + 32'd1;
            end else begin
               word_d = word_q + 2'd1;
            end
         end

         if (valid == 16'hFFFF) begin
            // Vectors past the layer total are silently ignored.
            if (cap_cnt_q < LastVec) begin
               // A full buffer still accepts when the head retires this cycle.
               if (cnt_q != 2'd2 || pop) begin
                  push      = 1'b1;
                  wr_ptr_d  = ~wr_ptr_q;
                  cap_cnt_d = cap_cnt_q + 32'd1;
               end else begin
                  overflow_d = 1'b1;
               end
            end
         end else if (valid != 16'h0000) begin
            lane_err_d = 1'b1;
         end

         cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

         if (vec_cnt_q == LastVec) begin
            state_d = StDone;
         end
      end
   end

   // State, buffer and registered write-port outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         mem_q[0]   <= '0;
         mem_q[1]   <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         cnt_q      <= 2'd0;
         word_q     <= 2'd0;
         cap_cnt_q  <= 32'd0;
         vec_cnt_q  <= 32'd0;
         addr_q     <= 32'd0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= 32'd0;
         wr_data_q  <= 32'd0;
         overflow_q <= 1'b0;
         lane_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         word_q     <= word_d;
         cap_cnt_q  <= cap_cnt_d;
         vec_cnt_q  <= vec_cnt_d;
         addr_q     <= addr_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         overflow_q <= overflow_d;
         lane_err_q <= lane_err_d;
         if (push) begin
            mem_q[wr_ptr_q] <= cap_vec;
         end
      end
   end

   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign busy     = (state_q == StRun);
   assign done     = (state_q == StDone);
   assign overflow = overflow_q;
   assign lane_err = lane_err_q;

endmodule

// File: tb/tb_ofm_writeback.sv
// Scoreboard bench for ofm_writeback: expected writes are queued at stimulus time and
// a forked monitor pops and compares every write strobe of either instance.
module tb_ofm_writeback;

   logic        clk = 1'b0;
   logic        reset_a, reset_b, start_a, start_b;
   logic [15:0] valid;
   logic [7:0]  ofm [16];
   logic        wr_en_a, busy_a, done_a, overflow_a, lane_err_a;
   logic        wr_en_b, busy_b, done_b, overflow_b, lane_err_b;
   logic [31:0] wr_addr_a, wr_data_a, wr_addr_b, wr_data_b;

   logic [63:0] exp_a [$];
   logic [63:0] exp_b [$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          n_wr_a = 0;
   int          n_wr_b = 0;

   always #5 clk = ~clk;

   ofm_writeback #(.OFM_BASE(32'h0), .TOTAL_PIX(2916), .CH_GROUPS(2)) u_dut_a (
      .clk(clk), .reset(reset_a), .start(start_a), .valid(valid),
      .OFM_0(ofm[0]), .OFM_1(ofm[1]), .OFM_2(ofm[2]), .OFM_3(ofm[3]),
      .OFM_4(ofm[4]), .OFM_5(ofm[5]), .OFM_6(ofm[6]), .OFM_7(ofm[7]),
      .OFM_8(ofm[8]), .OFM_9(ofm[9]), .OFM_10(ofm[10]), .OFM_11(ofm[11]),
      .OFM_12(ofm[12]), .OFM_13(ofm[13]), .OFM_14(ofm[14]), .OFM_15(ofm[15]),
      .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .busy(busy_a),
      .done(done_a), .overflow(overflow_a), .lane_err(lane_err_a)
   );

   ofm_writeback #(.OFM_BASE(32'hFFFF_FFFE), .TOTAL_PIX(2), .CH_GROUPS(2)) u_dut_b (
      .clk(clk), .reset(reset_b), .start(start_b), .valid(valid),
      .OFM_0(ofm[0]), .OFM_1(ofm[1]), .OFM_2(ofm[2]), .OFM_3(ofm[3]),
      .OFM_4(ofm[4]), .OFM_5(ofm[5]), .OFM_6(ofm[6]), .OFM_7(ofm[7]),
      .OFM_8(ofm[8]), .OFM_9(ofm[9]), .OFM_10(ofm[10]), .OFM_11(ofm[11]),
      .OFM_12(ofm[12]), .OFM_13(ofm[13]), .OFM_14(ofm[14]), .OFM_15(ofm[15]),
      .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .busy(busy_b),
      .done(done_b), .overflow(overflow_b), .lane_err(lane_err_b)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Lane i carries base+i; the expected word k is then {b+4k+3, b+4k+2, b+4k+1, b+4k}.
   task automatic set_ofm(input int base);
      for (int i = 0; i < 16; i++) ofm[i] = 8'(base + i);
   endtask

   function automatic logic [31:0] word_of(input int base, input int k);
      int b;
      b = base + 4 * k;
      return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
   endfunction

   task automatic expect_vec_a(input int base, input logic [31:0] addr0);
      for (int k = 0; k < 4; k++) exp_a.push_back({addr0 + 32'(k), word_of(base, k)});
   endtask

   task automatic expect_vec_b(input int base, input logic [31:0] addr0);
      for (int k = 0; k < 4; k++) exp_b.push_back({addr0 + 32'(k), word_of(base, k)});
   endtask

   task automatic monitor();
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (wr_en_a) begin
            n_wr_a++;
            if (exp_a.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL a_unexpected_write: got addr %0h data %0h, expected none",
                        wr_addr_a, wr_data_a);
            end else begin
               e = exp_a.pop_front();
               check("a_write", {wr_addr_a, wr_data_a}, e);
            end
         end
         if (wr_en_b) begin
            n_wr_b++;
            if (exp_b.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL b_unexpected_write: got addr %0h data %0h, expected none",
                        wr_addr_b, wr_data_b);
            end else begin
               e = exp_b.pop_front();
               check("b_write", {wr_addr_b, wr_data_b}, e);
            end
         end
      end
   endtask

   initial begin
      int base_wr;
      reset_a = 1'b1;
      reset_b = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      valid   = 16'h0;
      set_ofm(0);
      fork
         monitor();
      join_none
      tick();
      tick();
      check("reset_a_outputs", 64'({wr_en_a, wr_addr_a, wr_data_a, busy_a, done_a,
                                    overflow_a, lane_err_a}), 64'h0);
      check("reset_b_outputs", 64'({wr_en_b, busy_b, done_b, overflow_b, lane_err_b}), 64'h0);

      // One capture with lane i = i+1; first word registered one edge after capture.
      reset_a = 1'b0;
      tick();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      check("a_busy_after_start", 64'(busy_a), 64'h1);
      exp_a.push_back({32'd0, 32'h0403_0201});
      exp_a.push_back({32'd1, 32'h0807_0605});
      exp_a.push_back({32'd2, 32'h0C0B_0A09});
      exp_a.push_back({32'd3, 32'h100F_0E0D});
      set_ofm(1);
      valid = 16'hFFFF;
      tick();
      valid = 16'h0;
      check("a_latency_no_write_at_capture", 64'(wr_en_a), 64'h0);
      tick();
      check("a_first_word_next_edge", 64'(wr_en_a), 64'h1);
      repeat (6) tick();
      check("a_single_vec_writes", 64'(n_wr_a), 64'd4);

      // Three back-to-back captures via restart: third is dropped.
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      base_wr = n_wr_a;
      for (int v = 0; v < 3; v++) begin
         set_ofm(16 * (v + 1));
         if (v < 2) expect_vec_a(16 * (v + 1), 32'(4 * v));
         valid = 16'hFFFF;
         tick();
      end
      valid = 16'h0;
      repeat (12) tick();
      check("a_overflow_set", 64'(overflow_a), 64'h1);
      check("a_overflow_write_count", 64'(n_wr_a - base_wr), 64'd8);

      // Partial valid: no capture, lane_err sticks until the next start.
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      check("a_restart_clears_overflow", 64'(overflow_a), 64'h0);
      base_wr = n_wr_a;
      set_ofm(200);
      valid = 16'h00FF;
      tick();
      valid = 16'h0;
      check("a_lane_err_set", 64'(lane_err_a), 64'h1);
      repeat (6) tick();
      check("a_partial_no_write", 64'(n_wr_a - base_wr), 64'd0);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      check("a_start_clears_lane_err", 64'(lane_err_a), 64'h0);

      // Reset on the edge that would issue the second word aborts the drain.
      base_wr = n_wr_a;
      set_ofm(64);
      exp_a.push_back({32'd0, word_of(64, 0)});
      valid = 16'hFFFF;
      tick();
      valid = 16'h0;
      tick();
      reset_a = 1'b1;
      tick();
      check("a_mid_drain_reset_outputs", 64'({wr_en_a, wr_addr_a, wr_data_a, busy_a, done_a,
                                             overflow_a, lane_err_a}), 64'h0);
      reset_a = 1'b0;
      valid = 16'hFFFF;
      repeat (6) tick();
      valid = 16'h0;
      repeat (2) tick();
      check("a_idle_ignores_valid_busy", 64'(busy_a), 64'h0);
      check("a_abort_write_count", 64'(n_wr_a - base_wr), 64'd1);
      check("a_queue_drained", 64'(exp_a.size()), 64'd0);

      // Second instance: address wrap, then layer completion with 4 vectors.
      reset_a = 1'b1;
      reset_b = 1'b0;
      tick();
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      exp_b.push_back({32'hFFFF_FFFE, word_of(32, 0)});
      exp_b.push_back({32'hFFFF_FFFF, word_of(32, 1)});
      exp_b.push_back({32'h0000_0000, word_of(32, 2)});
      exp_b.push_back({32'h0000_0001, word_of(32, 3)});
      set_ofm(32);
      valid = 16'hFFFF;
      tick();
      valid = 16'h0;
      repeat (6) tick();
      check("b_wrap_write_count", 64'(n_wr_b), 64'd4);

      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      base_wr = n_wr_b;
      for (int c = 0; c < 5; c++) begin
         set_ofm(128 + 16 * c);
         if (c < 4) expect_vec_b(128 + 16 * c, 32'hFFFF_FFFE + 32'(4 * c));
         valid = 16'hFFFF;
         tick();
         valid = 16'h0;
         for (int j = 1; j <= 5; j++) begin
            tick();
            if (c == 3 && j == 4) check("b_not_done_during_last_word", 64'(done_b), 64'h0);
            if (c == 3 && j == 5) begin
               check("b_done_after_last", 64'(done_b), 64'h1);
               check("b_busy_low_after_last", 64'(busy_b), 64'h0);
            end
         end
      end
      repeat (4) tick();
      check("b_total_writes", 64'(n_wr_b - base_wr), 64'd16);
      check("b_still_done", 64'({done_b, busy_b}), 64'b10);
      check("b_no_overflow", 64'(overflow_b), 64'h0);
      check("b_queue_drained", 64'(exp_b.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
